// File: rtl/mul_lp_pkg.sv
// mul_lp_pkg: shared definitions for the paired-multiplier operand feeder.
//   state_t  : sequencer state encoding (IDLE / FIRST / SECOND)
//   DEF_OP_W : default operand width
//   PAIR_LEN : operands per downstream multiply pair
package mul_lp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  localparam int DEF_OP_W = 4;
  localparam int PAIR_LEN = 2;

endpackage

// File: rtl/op_fifo.sv
// op_fifo: DEPTH-entry operand-pair store with occupancy count.
// Ports:
//   clk, rstn   clock, async active-low reset (clears pointers and count)
//   push, din   write din at the write pointer
//   pop         advance the read pointer
//   dout        entry at the read pointer (combinational)
//   count       current occupancy, 0..DEPTH
// Storage contents are not reset; emptiness is tracked by count alone.
module op_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/mul_pair_feeder.sv
// mul_pair_feeder: buffers operand pairs and presents them to a downstream
// paired multiplier two at a time, so en only ever rises in even-length bursts.
//
// state  | meaning
// IDLE   | nothing presented; waits for two entries (or a pending flush)
// FIRST  | first operand of a pair on mul1/mul2, en high
// SECOND | second operand of a pair on mul1/mul2, en high
//
// Ports:
//   clk, rstn         clock, async active-low reset
//   in_valid, in_ready, in_a, in_b   operand-pair input handshake
//   hold              block starting new pairs (an in-flight pair completes)
//   flush             pulse: drain a lone leftover entry when idle
//   en, mul1, mul2    registered downstream operand interface
//   busy              anything in flight, buffered or pending
//
// Build option: MUL_PAIR_ZERO_PAD_EN -- a flushed lone entry is issued as
// FIRST and padded with a zero SECOND; otherwise it is silently discarded.
module mul_pair_feeder
  import mul_lp_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int OP_W  = DEF_OP_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_a,
  input  logic [OP_W-1:0] in_b,
  input  logic            hold,
  input  logic            flush,
  output logic            en,
  output logic [OP_W-1:0] mul1,
  output logic [OP_W-1:0] mul2,
  output logic            busy
);

  state_t            state, state_nxt;
  logic [CW-1:0]     count;
  logic [2*OP_W-1:0] fifo_dout;
  logic              push, pop;
  logic              load, load_zero;
  logic              pad, pad_nxt;
  logic              flush_pend, fp_clr;
  logic              start_ok;

  // No same-cycle pop credit: a full FIFO refuses even while popping.
  assign in_ready = rstn & (count < CW'(DEPTH));
  assign push     = in_valid & in_ready;

  op_fifo #(
    .DEPTH (DEPTH),
    .W     (2*OP_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   ({in_a, in_b}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (count)
  );

  // Pre-edge count only: a pair never starts unless both halves are already stored.
  assign start_ok = (count >= CW'(PAIR_LEN)) & ~hold;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    load_zero = 1'b0;
    pad_nxt   = pad;
    fp_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = FIRST;
          pop       = 1'b1;
          load      = 1'b1;
        end else if (flush_pend) begin
          if (count == '0) begin
            fp_clr = 1'b1;
          end else if (count == CW'(1)) begin
`ifdef MUL_PAIR_ZERO_PAD_EN
            if (!hold) begin
              state_nxt = FIRST;
              pop       = 1'b1;
              load      = 1'b1;
              pad_nxt   = 1'b1;
              fp_clr    = 1'b1;
            end
`else
            pop    = 1'b1;
            fp_clr = 1'b1;
`endif
          end
        end
      end
      FIRST: begin
        state_nxt = SECOND;
        pad_nxt   = 1'b0;
        if (pad) begin
          load_zero = 1'b1;
        end else begin
          pop  = 1'b1;
          load = 1'b1;
        end
      end
      SECOND: begin
        if (start_ok) begin
          state_nxt = FIRST;
          pop       = 1'b1;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      en         <= 1'b0;
      mul1       <= '0;
      mul2       <= '0;
      pad        <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      en    <= (state_nxt != IDLE);
      pad   <= pad_nxt;
      // A flush arriving while one is pending is absorbed by the OR.
      flush_pend <= fp_clr ? 1'b0 : (flush_pend | flush);
      if (load) begin
        {mul1, mul2} <= fifo_dout;
      end else if (load_zero) begin
        mul1 <= '0;
        mul2 <= '0;
      end
    end
  end

  assign busy = (state != IDLE) | (count != '0) | flush_pend;

endmodule

// File: doc/mul_pair_feeder.md
MUL_PAIR_FEEDER -- requirements
Module: mul_pair_feeder

Interface
REQ-001 Parameter DEPTH, 4, FIFO entries; SHALL be a power of two and at least 2.
REQ-002 Parameter OP_W, 4, operand width in bits.
REQ-003 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  operand pair offered.
REQ-006 in_ready  out  1  SHALL equal (count < DEPTH) and be combinational, with no same-cycle pop credit.
REQ-007 in_a, in_b  in  OP_W each  operands of the offered pair.
REQ-008 hold  in  1  when high, no new pair SHALL start; a pair already in progress SHALL complete.
REQ-009 flush  in  1  single-cycle pulse requesting drain of a lone leftover entry.
REQ-010 en  out  1  registered; high exactly while an operand is presented downstream.
REQ-011 mul1, mul2  out  OP_W each  registered operands, valid while en is high.
REQ-012 busy  out  1  SHALL equal (state != IDLE) | (count != 0) | flush_pend.

Function
REQ-013 Push SHALL occur when in_valid & in_ready; a push SHALL write {in_a, in_b} at wr_ptr.
REQ-014 Pointers SHALL wrap modulo DEPTH.
REQ-015 count SHALL update as count + push - pop, and a simultaneous push and pop SHALL leave count unchanged.
REQ-016 FSM states SHALL be IDLE, FIRST and SECOND; en SHALL be 1 in FIRST and in SECOND.
REQ-017 IDLE->FIRST SHALL occur when count >= 2 & ~hold, popping one entry into mul1/mul2.
REQ-018 FIRST->SECOND SHALL be unconditional, popping one entry into mul1/mul2.
REQ-019 SECOND->FIRST SHALL occur when count >= 2 & ~hold, popping one entry; otherwise SECOND->IDLE with en=0 and mul1/mul2 held.
REQ-020 All transition decisions SHALL use the pre-edge count, so a same-cycle push SHALL NOT count toward them.
REQ-021 en SHALL be high only in bursts of even length and SHALL stay high continuously across back-to-back pairs, so the downstream paired multiplier stays aligned.
REQ-022 Entries SHALL issue strictly in FIFO order.
REQ-023 flush SHALL set flush_pend.
REQ-024 flush_pend SHALL be evaluated only in IDLE: with count==0 it SHALL clear with no effect; with count>=2 it SHALL wait; with count==1 the action SHALL be per REQ-029/REQ-030, after which flush_pend SHALL clear.
REQ-025 flush while flush_pend is already set SHALL be ignored.

Reset
REQ-026 rstn low SHALL asynchronously force state=IDLE, en=0, mul1=mul2=0, count=0, wr_ptr=rd_ptr=0 and flush_pend=0.
REQ-027 in_ready SHALL be 0 while rstn is low.
REQ-028 Reset mid-pair SHALL drop the pair, with no SECOND cycle issued; FIFO contents SHALL be discarded.

Configuration
REQ-029 With macro MUL_PAIR_ZERO_PAD_EN defined, a honoured flush with count==1 (and ~hold) SHALL issue FIRST with the popped entry, then SECOND with mul1=mul2=0 and no pop.
REQ-030 With MUL_PAIR_ZERO_PAD_EN undefined, a honoured flush with count==1 SHALL discard the entry (count->0, rd_ptr advances) and en SHALL stay 0.

Structure
REQ-031 Shared package mul_lp_pkg SHALL hold the FSM state encoding (IDLE/FIRST/SECOND), default OP_W=4, and PAIR_LEN=2.
REQ-032 Storage SHALL be sub-module op_fifo (DEPTH x 2*OP_W, count/pointers); the FSM and output registers SHALL be in the top level.

Verification
REQ-033 Push (3,5) at edge1 and (2,7) at edge2 -> edge3 en=1 with (3,5); edge4 (2,7); edge5 en=0; downstream sum 29.
REQ-034 Push 4 pairs back-to-back, hold=0 -> en high 4 consecutive cycles, in order, busy falls after the last pair.
REQ-035 hold=1, push 4 -> in_ready=0 at count 4 and a 5th in_valid is not accepted; release hold -> 4 issues, then in_ready=1.
REQ-036 Push (9,9) then flush -> with ZERO_PAD_EN: en 2 cycles, (9,9) then (0,0), downstream sum 81; without: no en, count 0, busy 0.
REQ-037 rstn low during FIRST -> en, mul1 and mul2 go 0 immediately, no SECOND occurs, count 0 after release.
REQ-038 Push on the same edge as a SECOND->FIRST decision with pre-edge count 1 -> transition to IDLE and en falls; the pair starts on the next edge.
